// File: rtl/if_stage_if.sv
// Purpose: IMEM fetch port bundle for the MINA2000 instruction fetch stage.
// Signals:
//   req    : fetch request valid (driven by the fetch stage)
//   addr   : fetch word address, [1:0] always zero
//   gnt    : request accepted this cycle (req && gnt)
//   rvalid : response data valid
//   rdata  : fetched instruction word
// Modports: master = fetch stage side, slave = instruction memory side.
interface if_stage_if;
  localparam int unsigned XLEN = 32;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_stage.sv
// Purpose: Instruction Fetch stage of the MINA2000 pipeline.
//   Keeps the next fetch address, issues one word fetch at a time to IMEM,
//   and writes the IF/ID register consumed by id_stage. Holds on stall,
//   flushes and refetches on a taken branch/call redirect from EX.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem         : IMEM fetch port (master side of if_stage_if)
//   redirect     : taken branch/call from EX, flush and refetch
//   redirect_ia  : new fetch address, bits [1:0] ignored
//   stall        : hazard unit hold of the IF/ID contents
//   ir           : IF/ID instruction word
//   ia_plus_4    : IF/ID address of ir plus 4
//   valid        : IF/ID holds a real instruction
module if_stage #(
  parameter logic [31:0] RESET_IA = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  if_stage_if.master         imem,
  input  logic               redirect,
  input  logic [31:0]        redirect_ia,
  input  logic               stall,
  output logic [31:0]        ir,
  output logic [31:0]        ia_plus_4,
  output logic               valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] ia_plus_4;
  } ifid_t;

  state_t          state;
  logic            req_q;
  logic [XLEN-1:0] ia;
  logic [XLEN-1:0] fetch_p4;
  logic            kill;
  ifid_t           skid;
  logic            skid_full;

  // The request strobe is a register tracking the state; the address is the
  // next-fetch register itself, so both stay stable while gnt is withheld.
  assign imem.req  = req_q;
  assign imem.addr = ia;

  // Fetch FSM, fetch address, skid buffer and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      req_q     <= 1'b1;
      ia        <= RESET_IA;
      fetch_p4  <= '0;
      kill      <= 1'b0;
      skid      <= '0;
      skid_full <= 1'b0;
      ir        <= '0;
      ia_plus_4 <= '0;
      valid     <= 1'b0;
    end else if (redirect) begin
      // Redirect wins over stall: flush IF/ID and skid, retarget fetch.
      valid     <= 1'b0;
      ia        <= redirect_ia & ~XLEN'(3);
      skid_full <= 1'b0;
      case (state)
        S_REQ: begin
          if (imem.gnt) begin
            // Old-address fetch is now in flight; drop its response.
            state <= S_WAIT;
            req_q <= 1'b0;
            kill  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            state <= S_REQ;
            req_q <= 1'b1;
            kill  <= 1'b0;
          end else begin
            kill <= 1'b1;
          end
        end
        default: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem.gnt) begin
            fetch_p4 <= ia + XLEN'(4);
            ia       <= ia + XLEN'(4);
            state    <= S_WAIT;
            req_q    <= 1'b0;
          end
          // No instruction arrives in this state.
          if (!stall) valid <= 1'b0;
        end

        S_WAIT: begin
          if (imem.rvalid) begin
            state <= S_REQ;
            req_q <= 1'b1;
            if (kill) begin
              kill <= 1'b0;
              if (!stall) valid <= 1'b0;
            end else if (!stall || !valid) begin
              // Normal delivery, or a stalled bubble that can be filled.
              ir        <= imem.rdata;
              ia_plus_4 <= fetch_p4;
              valid     <= 1'b1;
            end else begin
              // ID is holding a real instruction: park the new one.
              skid      <= '{ir: imem.rdata, ia_plus_4: fetch_p4};
              skid_full <= 1'b1;
              state     <= S_HOLD;
              req_q     <= 1'b0;
            end
          end else if (!stall) begin
            valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (!stall && skid_full) begin
            ir        <= skid.ir;
            ia_plus_4 <= skid.ia_plus_4;
            valid     <= 1'b1;
            skid_full <= 1'b0;
            state     <= S_REQ;
            req_q     <= 1'b1;
          end
        end

        default: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Purpose: self-checking bench for if_stage. Directed cycle table, reset and
//   wrap sequences, then a randomised IMEM responder with a scoreboard of
//   expected IF/ID deliveries.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect, stall;
  logic [31:0] redirect_ia;
  logic [31:0] ir, ia_plus_4;
  logic        valid;

  logic        redirect2, stall2;
  logic [31:0] redirect_ia2;
  logic [31:0] ir2, ia_plus_4_2;
  logic        valid2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_stage_if imem ();
  if_stage_if imem2 ();

  if_stage #(.RESET_IA(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem(imem), .redirect(redirect),
    .redirect_ia(redirect_ia), .stall(stall), .ir(ir),
    .ia_plus_4(ia_plus_4), .valid(valid)
  );

  if_stage #(.RESET_IA(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem(imem2), .redirect(redirect2),
    .redirect_ia(redirect_ia2), .stall(stall2), .ir(ir2),
    .ia_plus_4(ia_plus_4_2), .valid(valid2)
  );

  typedef struct {
    logic        gnt, rvalid, stall, redirect;
    logic [31:0] rdata, rdia;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ir, exp_p4;
  } vec_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] p4;
  } exp_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];
  exp_t sbq [$];

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                              input logic st, input logic rdr, input logic [31:0] rdia,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.stall = st; v.redirect = rdr;
    v.rdia = rdia; v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev;
    v.exp_ir = ei; v.exp_p4 = ep;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        pending, rv, g, st, prev_valid, prev_stall;
    logic [31:0] pend_data, exp_addr;
    int          dly;
    exp_t        e;

    // Directed cycle table: inputs for the coming edge, outputs after it.
    //                 gnt rv rdata          st rdr rdia          req addr          v  ir             p4
    vecs[0]  = mk(1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    vecs[1]  = mk(0, 1, 32'h0,         0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h4);
    vecs[2]  = mk(1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h4);
    vecs[3]  = mk(0, 1, 32'h4,         0, 0, 32'h0,        1, 32'h8,        1, 32'h4,        32'h8);
    vecs[4]  = mk(1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h4,        32'h8);
    vecs[5]  = mk(0, 1, 32'h8,         0, 0, 32'h0,        1, 32'hC,        1, 32'h8,        32'hC);
    vecs[6]  = mk(1, 0, 32'h0,         1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'hC);
    vecs[7]  = mk(0, 1, 32'hDEAD,      1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'hC);
    vecs[8]  = mk(0, 0, 32'h0,         1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'hC);
    vecs[9]  = mk(0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h10,       1, 32'hDEAD,     32'h10);
    vecs[10] = mk(1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'hDEAD,     32'h10);
    vecs[11] = mk(0, 0, 32'h0,         0, 1, 32'h103,      0, 32'h0,        0, 32'hDEAD,     32'h10);
    vecs[12] = mk(0, 1, 32'hBAD,       0, 0, 32'h0,        1, 32'h100,      0, 32'hDEAD,     32'h10);
    vecs[13] = mk(1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'hDEAD,     32'h10);
    vecs[14] = mk(0, 1, 32'h1234,      0, 0, 32'h0,        1, 32'h104,      1, 32'h1234,     32'h104);
    vecs[15] = mk(0, 0, 32'h0,         1, 1, 32'h200,      1, 32'h200,      0, 32'h1234,     32'h104);
    vecs[16] = mk(1, 0, 32'h0,         0, 1, 32'h300,      0, 32'h0,        0, 32'h1234,     32'h104);
    vecs[17] = mk(0, 1, 32'hBEEF,      0, 0, 32'h0,        1, 32'h300,      0, 32'h1234,     32'h104);
    vecs[18] = mk(0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h300,      0, 32'h1234,     32'h104);
    vecs[19] = mk(1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h1234,     32'h104);
    vecs[20] = mk(0, 1, 32'h55,        0, 0, 32'h0,        1, 32'h304,      1, 32'h55,       32'h304);
    vecs[21] = mk(1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 32'h55,       32'h304);
    vecs[22] = mk(0, 1, 32'h66,        1, 0, 32'h0,        1, 32'h308,      1, 32'h66,       32'h308);
    vecs[23] = mk(0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h308,      0, 32'h66,       32'h308);
    vecs[24] = mk(0, 1, 32'h77,        0, 0, 32'h0,        1, 32'h308,      0, 32'h66,       32'h308);

    rst_n = 1'b0;
    redirect = 1'b0; stall = 1'b0; redirect_ia = '0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    redirect2 = 1'b0; stall2 = 1'b0; redirect_ia2 = '0;
    imem2.gnt = 1'b0; imem2.rvalid = 1'b0; imem2.rdata = '0;

    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset req",   {31'b0, imem.req}, 32'h1);
    chk("reset addr",  imem.addr,         32'h0);
    chk("reset valid", {31'b0, valid},    32'h0);
    chk("reset ir",    ir,                32'h0);
    chk("reset p4",    ia_plus_4,         32'h0);

    for (int i = 0; i < NVEC; i++) begin
      imem.gnt    = vecs[i].gnt;
      imem.rvalid = vecs[i].rvalid;
      imem.rdata  = vecs[i].rdata;
      stall       = vecs[i].stall;
      redirect    = vecs[i].redirect;
      redirect_ia = vecs[i].rdia;
      tick();
      chk($sformatf("v%0d req", i),   {31'b0, imem.req}, {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req) chk($sformatf("v%0d addr", i), imem.addr, vecs[i].exp_addr);
      chk($sformatf("v%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d ir", i),    ir,        vecs[i].exp_ir);
      chk($sformatf("v%0d p4", i),    ia_plus_4, vecs[i].exp_p4);
    end
    imem.gnt = 1'b0; imem.rvalid = 1'b0; stall = 1'b0; redirect = 1'b0;

    // Withheld grant: request and address must stay put.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("nogrant%0d req", i),  {31'b0, imem.req}, 32'h1);
      chk($sformatf("nogrant%0d addr", i), imem.addr,         32'h308);
    end
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0;
    chk("pre-reset wait req", {31'b0, imem.req}, 32'h0);

    // Reset pulse while a fetch is outstanding; the late response is ignored.
    rst_n = 1'b0;
    #2;
    chk("midreset ir",    ir,                32'h0);
    chk("midreset valid", {31'b0, valid},    32'h0);
    chk("midreset addr",  imem.addr,         32'h0);
    chk("midreset req",   {31'b0, imem.req}, 32'h1);
    tick();
    rst_n = 1'b1;
    imem.rvalid = 1'b1; imem.rdata = 32'h999;
    tick();
    imem.rvalid = 1'b0;
    chk("late rvalid valid", {31'b0, valid},    32'h0);
    chk("late rvalid ir",    ir,                32'h0);
    chk("late rvalid req",   {31'b0, imem.req}, 32'h1);
    chk("late rvalid addr",  imem.addr,         32'h0);

    // Address wrap from the top of the address space.
    chk("wrap first addr", imem2.addr, 32'hFFFF_FFFC);
    imem2.gnt = 1'b1;
    tick();
    imem2.gnt = 1'b0; imem2.rvalid = 1'b1; imem2.rdata = 32'h11;
    tick();
    imem2.rvalid = 1'b0;
    chk("wrap valid",       {31'b0, valid2},    32'h1);
    chk("wrap ir",          ir2,                32'h11);
    chk("wrap ia_plus_4",   ia_plus_4_2,        32'h0);
    chk("wrap second req",  {31'b0, imem2.req}, 32'h1);
    chk("wrap second addr", imem2.addr,         32'h0);

    // Randomised responder with stalls; every grant must reach IF/ID in order.
    pending = 1'b0; pend_data = '0; dly = 0;
    exp_addr = 32'h0; prev_valid = valid; prev_stall = 1'b0;
    for (int cyc = 0; cyc < 440; cyc++) begin
      if (valid && (!prev_valid || !prev_stall)) begin
        if (sbq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb unexpected: got ir %h expected none", ir);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("sb c%0d ir", cyc), ir,        e.ir);
          chk($sformatf("sb c%0d p4", cyc), ia_plus_4, e.p4);
        end
      end
      prev_valid = valid;

      rv = 1'b0;
      if (pending) begin
        if (dly == 0) begin
          rv = 1'b1; pending = 1'b0;
        end else begin
          dly--;
        end
      end

      g = 1'b0;
      if (imem.req) begin
        chk($sformatf("sb c%0d addr", cyc), imem.addr, exp_addr);
        if (cyc < 400 && !pending && !rv && $urandom_range(0, 2) != 0) begin
          g = 1'b1;
          sbq.push_back('{ir: mem_word(exp_addr), p4: exp_addr + 32'd4});
          pending   = 1'b1;
          dly       = int'($urandom_range(0, 2));
          exp_addr  = exp_addr + 32'd4;
        end
      end

      st = (cyc < 400) ? ($urandom_range(0, 2) == 0) : 1'b0;
      imem.rdata  = rv ? pend_data : 32'h0;
      imem.rvalid = rv;
      imem.gnt    = g;
      stall       = st;
      prev_stall  = st;
      if (g) pend_data = mem_word(imem.addr);
      tick();
    end
    imem.gnt = 1'b0; imem.rvalid = 1'b0; stall = 1'b0;
    chk("sb drained", 32'(sbq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
